// File: rtl/pcie_ltssm_link_monitor.sv
// PCIe LTSSM link monitor: glitch-filters the raw LTSSM code, classifies it into a
// four-state link FSM, keeps saturating link-health statistics and drives board LEDs.
module pcie_ltssm_link_monitor #(
    parameter int STABLE_CYCLES = 16,
    parameter int ALIVE_BITS    = 26,
    parameter int CNT_W         = 16
) (
    input  logic             pld_clk,
    input  logic             rst,
    input  logic [4:0]       ltssm_state,
    input  logic [3:0]       lane_act,
    input  logic             gen2_speed,
    input  logic             clr_stats,
    output logic [1:0]       link_state,
    output logic             link_up,
    output logic [CNT_W-1:0] link_down_cnt,
    output logic [CNT_W-1:0] recovery_cnt,
    output logic [CNT_W-1:0] train_cycles,
    output logic             alive_led,
    output logic             comp_led,
    output logic             l0_led,
    output logic             gen2_led,
    output logic [3:0]       lane_active_led
);

    typedef enum logic [1:0] {
        LS_DOWN  = 2'd0,
        LS_TRAIN = 2'd1,
        LS_UP    = 2'd2,
        LS_RECOV = 2'd3
    } link_t;

    localparam logic [7:0]       STAB_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [4:0]            raw_q;
    logic [4:0]            filt_q;
    logic [7:0]            stab_q;
    link_t                 state_q, state_d;
    logic [CNT_W-1:0]      down_cnt_q, rec_cnt_q, train_q, tr_q;
    logic                  armed_q;
    logic [ALIVE_BITS-1:0] alive_q;
    logic                  comp_q, l0_q, gen2_q;
    logic [3:0]            lane_q;

    logic ev_drop, ev_recov, ev_train_up, ev_direct_up, ev_train_start;

    function automatic link_t classify(input logic [4:0] code);
        case (code)
            5'h00, 5'h01, 5'h10, 5'h14: classify = LS_DOWN;
            5'h0F, 5'h15, 5'h16, 5'h17: classify = LS_UP;
            5'h0C, 5'h0D, 5'h0E, 5'h1A: classify = LS_RECOV;
            default:                    classify = LS_TRAIN;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // A code must be seen unchanged for STABLE_CYCLES samples before it reaches filt_q.
    always_ff @(posedge pld_clk) begin
        if (rst) begin
            raw_q  <= '0;
            stab_q <= '0;
            filt_q <= '0;
        end else begin
            raw_q <= ltssm_state;
            if (ltssm_state != raw_q)
                stab_q <= '0;
            else if (stab_q != STAB_MAX)
                stab_q <= stab_q + 8'd1;
            if (stab_q == STAB_MAX && raw_q != filt_q)
                filt_q <= raw_q;
        end
    end

    always_ff @(posedge pld_clk) begin
        if (rst) state_q <= LS_DOWN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = classify(filt_q);
        ev_drop        = 1'b0;
        ev_recov       = 1'b0;
        ev_train_up    = 1'b0;
        ev_direct_up   = 1'b0;
        ev_train_start = 1'b0;
        case (state_q)
            LS_DOWN: begin
                ev_train_start = (state_d == LS_TRAIN);
                ev_direct_up   = (state_d == LS_UP);
            end
            LS_TRAIN: ev_train_up = (state_d == LS_UP);
            LS_UP: begin
                ev_drop  = (state_d == LS_DOWN);
                ev_recov = (state_d == LS_RECOV);
            end
            LS_RECOV: ev_drop = (state_d == LS_DOWN);
            default: ;
        endcase
    end

    // The edge that leaves TRAINING still counts that last TRAINING cycle.
    always_ff @(posedge pld_clk) begin
        if (rst) begin
            tr_q    <= '0;
            armed_q <= 1'b0;
        end else begin
            if (ev_train_start)
                tr_q <= '0;
            else if (state_q == LS_TRAIN)
                tr_q <= sat_inc(tr_q);
            if (ev_train_start)
                armed_q <= 1'b1;
            else if (state_d == LS_DOWN || ev_train_up)
                armed_q <= 1'b0;
        end
    end

    always_ff @(posedge pld_clk) begin
        if (rst || clr_stats) begin
            down_cnt_q <= '0;
            rec_cnt_q  <= '0;
            train_q    <= '0;
        end else begin
            if (ev_drop)  down_cnt_q <= sat_inc(down_cnt_q);
            if (ev_recov) rec_cnt_q  <= sat_inc(rec_cnt_q);
            if (ev_train_up && armed_q)
                train_q <= sat_inc(tr_q);
            else if (ev_direct_up)
                train_q <= '0;
        end
    end

    always_ff @(posedge pld_clk) begin
        if (rst) begin
            comp_q  <= 1'b0;
            l0_q    <= 1'b0;
            gen2_q  <= 1'b0;
            lane_q  <= '0;
            alive_q <= '0;
        end else begin
            comp_q  <= (filt_q == 5'h03);
            l0_q    <= (filt_q == 5'h0F);
            gen2_q  <= gen2_speed & (state_q == LS_UP);
            lane_q  <= lane_act;
            alive_q <= alive_q + {{(ALIVE_BITS-1){1'b0}}, 1'b1};
        end
    end

    assign link_state      = state_q;
    assign link_up         = (state_q == LS_UP);
    assign link_down_cnt   = down_cnt_q;
    assign recovery_cnt    = rec_cnt_q;
    assign train_cycles    = train_q;
    assign alive_led       = alive_q[ALIVE_BITS-1];
    assign comp_led        = comp_q;
    assign l0_led          = l0_q;
    assign gen2_led        = gen2_q;
    assign lane_active_led = lane_q;

endmodule

// File: tb/tb_pcie_ltssm_link_monitor.sv
// Scoreboard bench for pcie_ltssm_link_monitor: expectations are queued as stimulus is
// driven and popped against the DUT outputs at the point they must be valid.
module tb_pcie_ltssm_link_monitor;

    localparam int S  = 4;
    localparam int AB = 6;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam int SEL_LINK  = 0;
    localparam int SEL_UP    = 1;
    localparam int SEL_DOWN  = 2;
    localparam int SEL_REC   = 3;
    localparam int SEL_TRAIN = 4;
    localparam int SEL_ALIVE = 5;
    localparam int SEL_COMP  = 6;
    localparam int SEL_L0    = 7;
    localparam int SEL_GEN2  = 8;
    localparam int SEL_LANE  = 9;

    logic          pld_clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    ltssm_state = 5'h00;
    logic [3:0]    lane_act = 4'h0;
    logic          gen2_speed = 1'b0;
    logic          clr_stats = 1'b0;
    logic [1:0]    link_state;
    logic          link_up;
    logic [CW-1:0] link_down_cnt, recovery_cnt, train_cycles;
    logic          alive_led, comp_led, l0_led, gen2_led;
    logic [3:0]    lane_active_led;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  rec_model;

    pcie_ltssm_link_monitor #(.STABLE_CYCLES(S), .ALIVE_BITS(AB), .CNT_W(CW)) dut (
        .pld_clk(pld_clk), .rst(rst), .ltssm_state(ltssm_state), .lane_act(lane_act),
        .gen2_speed(gen2_speed), .clr_stats(clr_stats), .link_state(link_state),
        .link_up(link_up), .link_down_cnt(link_down_cnt), .recovery_cnt(recovery_cnt),
        .train_cycles(train_cycles), .alive_led(alive_led), .comp_led(comp_led),
        .l0_led(l0_led), .gen2_led(gen2_led), .lane_active_led(lane_active_led)
    );

    always #5 pld_clk = ~pld_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            SEL_LINK:  observe = 16'(link_state);
            SEL_UP:    observe = 16'(link_up);
            SEL_DOWN:  observe = 16'(link_down_cnt);
            SEL_REC:   observe = 16'(recovery_cnt);
            SEL_TRAIN: observe = 16'(train_cycles);
            SEL_ALIVE: observe = 16'(alive_led);
            SEL_COMP:  observe = 16'(comp_led);
            SEL_L0:    observe = 16'(l0_led);
            SEL_GEN2:  observe = 16'(gen2_led);
            SEL_LANE:  observe = 16'(lane_active_led);
            default:   observe = 16'hDEAD;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input int exp);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = 16'(exp);
        sb_q.push_back(e);
    endtask

    task automatic sb_drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge pld_clk);
        #1;
    endtask

    initial begin
        step(3);
        rst = 1'b0;

        // reset values
        expect_val("rst_link", SEL_LINK, 0);
        expect_val("rst_up", SEL_UP, 0);
        expect_val("rst_down", SEL_DOWN, 0);
        expect_val("rst_rec", SEL_REC, 0);
        expect_val("rst_train", SEL_TRAIN, 0);
        expect_val("rst_alive", SEL_ALIVE, 0);
        expect_val("rst_comp", SEL_COMP, 0);
        expect_val("rst_l0", SEL_L0, 0);
        expect_val("rst_gen2", SEL_GEN2, 0);
        expect_val("rst_lane", SEL_LANE, 0);
        sb_drain();

        // lane LEDs: one-cycle, unfiltered
        lane_act = 4'hA;
        expect_val("lane_a", SEL_LANE, 'hA);
        step(1); sb_drain();
        lane_act = 4'h5;
        expect_val("lane_5", SEL_LANE, 'h5);
        step(1); sb_drain();

        // heartbeat MSB rises after 2^(AB-1) cycles
        expect_val("alive_before", SEL_ALIVE, 0);
        step((1 << (AB - 1)) - 3); sb_drain();
        expect_val("alive_after", SEL_ALIVE, 1);
        step(1); sb_drain();

        // bring-up: 0x02 for 20 cycles then 0x0F
        gen2_speed  = 1'b1;
        ltssm_state = 5'h02;
        expect_val("bu_still_down", SEL_LINK, 0);
        step(S + 1); sb_drain();
        expect_val("bu_training", SEL_LINK, 1);
        expect_val("bu_gen2_not_up", SEL_GEN2, 0);
        step(1); sb_drain();
        step(20 - S - 2);
        ltssm_state = 5'h0F;
        expect_val("bu_l0_before", SEL_L0, 0);
        expect_val("bu_up_before", SEL_UP, 0);
        step(S + 1); sb_drain();
        expect_val("bu_link_up", SEL_LINK, 2);
        expect_val("bu_up", SEL_UP, 1);
        expect_val("bu_l0", SEL_L0, 1);
        expect_val("bu_train_sat", SEL_TRAIN, (20 > CMAX) ? CMAX : 20);
        expect_val("bu_gen2_lag", SEL_GEN2, 0);
        step(1); sb_drain();
        expect_val("bu_gen2", SEL_GEN2, 1);
        step(1); sb_drain();

        // 3-cycle glitch is filtered out
        ltssm_state = 5'h00;
        step(S - 1);
        ltssm_state = 5'h0F;
        expect_val("g3_link", SEL_LINK, 2);
        expect_val("g3_down", SEL_DOWN, 0);
        expect_val("g3_l0", SEL_L0, 1);
        step(10); sb_drain();

        // 4-cycle glitch reaches the FSM, then direct DOWN->UP latches 0
        ltssm_state = 5'h00;
        step(S);
        ltssm_state = 5'h0F;
        expect_val("g4_link_down", SEL_LINK, 0);
        expect_val("g4_down_cnt", SEL_DOWN, 1);
        expect_val("g4_l0_off", SEL_L0, 0);
        step(2); sb_drain();
        expect_val("g4_link_back", SEL_LINK, 2);
        expect_val("g4_train_zero", SEL_TRAIN, 0);
        step(S); sb_drain();
        step(2);

        // exact training time below saturation
        ltssm_state = 5'h00;
        step(10);
        ltssm_state = 5'h02;
        step(10);
        ltssm_state = 5'h0F;
        expect_val("t10_link", SEL_LINK, 2);
        expect_val("t10_train", SEL_TRAIN, 10);
        expect_val("t10_down_cnt", SEL_DOWN, 2);
        step(S + 2); sb_drain();

        // recovery entries saturate
        rec_model = 0;
        for (int i = 0; i < 20; i++) begin
            ltssm_state = 5'h0D;
            step(S + 2);
            ltssm_state = 5'h0F;
            rec_model = (rec_model == CMAX) ? CMAX : rec_model + 1;
            expect_val("rec_cnt", SEL_REC, rec_model);
            step(S + 2); sb_drain();
        end
        expect_val("rec_hold", SEL_REC, CMAX);
        expect_val("rec_down_unch", SEL_DOWN, 2);
        step(10); sb_drain();

        // clear coincident with RECOVERY->DOWN wins over the increment
        ltssm_state = 5'h0D;
        step(8);
        ltssm_state = 5'h00;
        step(S + 1);
        clr_stats = 1'b1;
        step(1);
        clr_stats = 1'b0;
        expect_val("clr_link", SEL_LINK, 0);
        expect_val("clr_down", SEL_DOWN, 0);
        expect_val("clr_rec", SEL_REC, 0);
        expect_val("clr_train", SEL_TRAIN, 0);
        sb_drain();

        // compliance code is TRAINING and lights comp_led; no gen2 while not UP
        ltssm_state = 5'h03;
        expect_val("comp_led", SEL_COMP, 1);
        expect_val("comp_link", SEL_LINK, 1);
        expect_val("comp_gen2", SEL_GEN2, 0);
        step(S + 3); sb_drain();

        // reset mid-training
        rst = 1'b1;
        expect_val("mrst_link", SEL_LINK, 0);
        expect_val("mrst_comp", SEL_COMP, 0);
        step(1); sb_drain();
        rst = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
